// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between execute and the data memory port: runs one req/ack
// transaction per accepted operation, steering byte lanes and extending load data.
package mem_access_sequencer_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef struct packed {
    mem_width_t  width;
    logic        r_sign_extend;
    logic        w_enable;
    logic [31:0] w_value;
  } compute_mem_control_t;

  typedef logic [4:0] rv_reg_t;
endpackage

module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [XLEN-1:0]      issue_addr,
  input  logic                 issue_is_load,
  input  compute_mem_control_t issue_mem,
  input  rv_reg_t              issue_rd,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [XLEN-1:0]      dmem_addr,
  output logic [XLEN-1:0]      dmem_wdata,
  output logic [3:0]           dmem_byte_en,
  input  logic                 dmem_ack,
  input  logic [XLEN-1:0]      dmem_rdata,
  output logic                 wb_valid,
  output rv_reg_t              wb_rd,
  output logic [XLEN-1:0]      wb_value,
  output logic                 stall,
  output logic                 misaligned_fault,
  output logic                 bus_fault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(MAX_WAIT - 1);

  state_t          state_q, state_d;
  logic [1:0]      lane_q, lane_d;
  mem_width_t      width_q, width_d;
  logic            sign_q, sign_d;
  rv_reg_t         rd_q, rd_d;
  logic [7:0]      count_q, count_d;
  logic            dmem_req_q, dmem_req_d;
  logic            dmem_we_q, dmem_we_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]      dmem_byte_en_q, dmem_byte_en_d;
  logic            wb_valid_q, wb_valid_d;
  rv_reg_t         wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_value_q, wb_value_d;
  logic            stall_q, stall_d;
  logic            misaligned_fault_q, misaligned_fault_d;
  logic            bus_fault_q, bus_fault_d;

  logic            accept;
  logic            misaligned;

  function automatic logic [3:0] lane_enables(input mem_width_t width, input logic [1:0] lane);
    case (width)
      MEM_BYTE: lane_enables = 4'b0001 << lane;
      MEM_HALF: lane_enables = 4'b0011 << lane;
      default:  lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] replicate(input mem_width_t width, input logic [XLEN-1:0] value);
    case (width)
      MEM_BYTE: replicate = {4{value[7:0]}};
      MEM_HALF: replicate = {2{value[15:0]}};
      default:  replicate = value;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] word, input logic [1:0] lane,
                                              input mem_width_t width, input logic sign_ext);
    logic [XLEN-1:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (width)
      MEM_BYTE: extract = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      MEM_HALF: extract = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:  extract = word;
    endcase
  endfunction

  assign accept = issue_valid && (state_q == IDLE) && (issue_is_load || issue_mem.w_enable);

  // The reserved width encoding is treated as a word access everywhere.
  always_comb begin
    case (issue_mem.width)
      MEM_BYTE: misaligned = 1'b0;
      MEM_HALF: misaligned = issue_addr[0];
      default:  misaligned = (issue_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    state_d            = state_q;
    lane_d             = lane_q;
    width_d            = width_q;
    sign_d             = sign_q;
    rd_d               = rd_q;
    count_d            = count_q;
    dmem_req_d         = dmem_req_q;
    dmem_we_d          = dmem_we_q;
    dmem_addr_d        = dmem_addr_q;
    dmem_wdata_d       = dmem_wdata_q;
    dmem_byte_en_d     = dmem_byte_en_q;
    wb_valid_d         = 1'b0;
    wb_rd_d            = wb_rd_q;
    wb_value_d         = wb_value_q;
    misaligned_fault_d = 1'b0;
    bus_fault_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          lane_d  = issue_addr[1:0];
          width_d = issue_mem.width;
          sign_d  = issue_mem.r_sign_extend;
          rd_d    = issue_rd;
          count_d = 8'd0;
          if (misaligned) begin
            state_d            = FAULT;
            misaligned_fault_d = 1'b1;
          end else begin
            state_d        = BUSY;
            dmem_req_d     = 1'b1;
            dmem_we_d      = !issue_is_load;
            dmem_addr_d    = {issue_addr[XLEN-1:2], 2'b00};
            dmem_byte_en_d = lane_enables(issue_mem.width, issue_addr[1:0]);
            dmem_wdata_d   = issue_is_load ? '0 : replicate(issue_mem.width, issue_mem.w_value);
          end
        end
      end
      // An ack in the last allowed cycle wins over the timeout.
      BUSY: begin
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            state_d = IDLE;
          end else begin
            state_d    = RESPOND;
            wb_valid_d = (rd_q != 5'd0);
            wb_rd_d    = rd_q;
            wb_value_d = extract(dmem_rdata, lane_q, width_q, sign_q);
          end
        end else if (count_q == LAST_COUNT) begin
          state_d     = IDLE;
          dmem_req_d  = 1'b0;
          bus_fault_d = 1'b1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      RESPOND: state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      lane_q             <= 2'b00;
      width_q            <= MEM_BYTE;
      sign_q             <= 1'b0;
      rd_q               <= '0;
      count_q            <= 8'd0;
      dmem_req_q         <= 1'b0;
      dmem_we_q          <= 1'b0;
      dmem_addr_q        <= '0;
      dmem_wdata_q       <= '0;
      dmem_byte_en_q     <= 4'b0000;
      wb_valid_q         <= 1'b0;
      wb_rd_q            <= '0;
      wb_value_q         <= '0;
      stall_q            <= 1'b0;
      misaligned_fault_q <= 1'b0;
      bus_fault_q        <= 1'b0;
    end else begin
      state_q            <= state_d;
      lane_q             <= lane_d;
      width_q            <= width_d;
      sign_q             <= sign_d;
      rd_q               <= rd_d;
      count_q            <= count_d;
      dmem_req_q         <= dmem_req_d;
      dmem_we_q          <= dmem_we_d;
      dmem_addr_q        <= dmem_addr_d;
      dmem_wdata_q       <= dmem_wdata_d;
      dmem_byte_en_q     <= dmem_byte_en_d;
      wb_valid_q         <= wb_valid_d;
      wb_rd_q            <= wb_rd_d;
      wb_value_q         <= wb_value_d;
      stall_q            <= stall_d;
      misaligned_fault_q <= misaligned_fault_d;
      bus_fault_q        <= bus_fault_d;
    end
  end

  assign issue_ready      = (state_q == IDLE);
  assign dmem_req         = dmem_req_q;
  assign dmem_we          = dmem_we_q;
  assign dmem_addr        = dmem_addr_q;
  assign dmem_wdata       = dmem_wdata_q;
  assign dmem_byte_en     = dmem_byte_en_q;
  assign wb_valid         = wb_valid_q;
  assign wb_rd            = wb_rd_q;
  assign wb_value         = wb_value_q;
  assign stall            = stall_q;
  assign misaligned_fault = misaligned_fault_q;
  assign bus_fault        = bus_fault_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios plus randomized
// operations checked against a transaction-level reference model.
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;

  localparam int MW = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 issue_valid = 1'b0;
  logic                 issue_ready;
  logic [31:0]          issue_addr = '0;
  logic                 issue_is_load = 1'b0;
  compute_mem_control_t issue_mem = '0;
  rv_reg_t              issue_rd = '0;
  logic                 dmem_req;
  logic                 dmem_we;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic [3:0]           dmem_byte_en;
  logic                 dmem_ack = 1'b0;
  logic [31:0]          dmem_rdata = '0;
  logic                 wb_valid;
  rv_reg_t              wb_rd;
  logic [31:0]          wb_value;
  logic                 stall;
  logic                 misaligned_fault;
  logic                 bus_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          req_cycles;
    int          ready_cycle;
    int          stall_low_cycle;
    int          wb_count;
    int          mis_count;
    int          bus_count;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    rv_reg_t     wb_rd;
    logic [31:0] wb_value;
  } obs_t;

  typedef struct {
    bit          mis;
    bit          bus;
    int          req_cycles;
    int          ready_cycle;
    int          wb_count;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wb_value;
  } exp_t;

  mem_access_sequencer #(.XLEN(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
    .issue_is_load(issue_is_load), .issue_mem(issue_mem), .issue_rd(issue_rd),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_byte_en(dmem_byte_en), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_value(wb_value), .stall(stall),
    .misaligned_fault(misaligned_fault), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Transaction-level model: everything follows from access size, lane and ack delay.
  function automatic exp_t model(input logic [31:0] addr, input bit is_load, input int nbytes,
                                 input bit sx, input logic [31:0] wval, input rv_reg_t rd,
                                 input int ack_delay, input logic [31:0] rdata);
    exp_t   e;
    int     a;
    longint v;
    longint span;
    a = int'(addr[1:0]);
    e.mis = (addr % nbytes) != 0;
    e.bus = !e.mis && (ack_delay >= MW);
    e.addr = addr - 32'(a);
    e.be = 4'(((1 << nbytes) - 1) << a);
    e.we = !is_load;
    if (is_load) e.wdata = 32'd0;
    else if (nbytes == 1) e.wdata = (wval % 256) * 32'h01010101;
    else if (nbytes == 2) e.wdata = (wval % 65536) * 32'h00010001;
    else e.wdata = wval;
    v = longint'(rdata) / (longint'(1) << (8 * a));
    if (nbytes < 4) begin
      span = longint'(1) << (8 * nbytes);
      v = v % span;
      if (sx && v >= span / 2) v = v - span;
    end
    e.wb_value = 32'(v);
    if (e.mis) begin
      e.req_cycles = 0; e.ready_cycle = 2;
    end else if (e.bus) begin
      e.req_cycles = MW; e.ready_cycle = MW + 1;
    end else begin
      e.req_cycles = ack_delay + 1;
      e.ready_cycle = is_load ? ack_delay + 3 : ack_delay + 2;
    end
    e.wb_count = (!e.mis && !e.bus && is_load && rd != 0) ? 1 : 0;
    return e;
  endfunction

  // Issues one operation, plays the memory side and records what the DUT did.
  task automatic do_op(input logic [31:0] addr, input bit is_load, input int nbytes, input bit sx,
                       input logic [31:0] wval, input rv_reg_t rd, input int ack_delay,
                       input logic [31:0] rdata, output obs_t o);
    o = '{default: 0};
    o.ready_cycle = -1;
    o.stall_low_cycle = -1;
    @(negedge clk);
    issue_valid = 1'b1;
    issue_addr = addr;
    issue_is_load = is_load;
    issue_mem.width = (nbytes == 1) ? MEM_BYTE : (nbytes == 2) ? MEM_HALF : MEM_WORD;
    issue_mem.r_sign_extend = sx;
    issue_mem.w_enable = !is_load;
    issue_mem.w_value = wval;
    issue_rd = rd;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (dmem_req) begin
        if (o.req_cycles == 0) begin
          o.addr = dmem_addr; o.wdata = dmem_wdata; o.be = dmem_byte_en; o.we = dmem_we;
        end
        o.req_cycles++;
      end
      if (wb_valid) begin o.wb_count++; o.wb_rd = wb_rd; o.wb_value = wb_value; end
      if (misaligned_fault) o.mis_count++;
      if (bus_fault) o.bus_count++;
      if (!stall && o.stall_low_cycle < 0) o.stall_low_cycle = n;
      if (issue_ready) begin o.ready_cycle = n; break; end
      if (dmem_req && (o.req_cycles - 1 == ack_delay)) begin
        dmem_ack = 1'b1; dmem_rdata = rdata;
      end else begin
        dmem_ack = 1'b0; dmem_rdata = $urandom;
      end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    if (dmem_req) o.req_cycles++;
    if (wb_valid) o.wb_count++;
    if (misaligned_fault) o.mis_count++;
    if (bus_fault) o.bus_count++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, wb_valid, wb_rd, wb_value,
         stall, misaligned_fault, bus_fault} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b we=%b addr=%h wdata=%h be=%b wbv=%b stall=%b mf=%b bf=%b want all zero",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, wb_valid, stall, misaligned_fault, bus_fault);
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", issue_ready); end
  endtask

  task automatic test_store_word();
    obs_t o;
    do_op(32'h100, 1'b0, 4, 1'b0, 32'hDEADBEEF, 5'd9, 1, 32'h0, o);
    checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h want 00000100", o.addr); end
    checks++; if (o.be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", o.be); end
    checks++; if (o.we !== 1'b1) begin errors++; $display("FAIL sw_we got %b want 1", o.we); end
    checks++; if (o.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", o.wdata); end
    checks++; if (o.req_cycles != 2) begin errors++; $display("FAIL sw_req_cycles got %0d want 2", o.req_cycles); end
    checks++; if (o.stall_low_cycle != 3) begin errors++; $display("FAIL sw_stall got low at %0d want 3", o.stall_low_cycle); end
    checks++; if (o.ready_cycle != 3) begin errors++; $display("FAIL sw_ready got %0d want 3", o.ready_cycle); end
    checks++; if (o.wb_count != 0) begin errors++; $display("FAIL sw_wb got %0d want 0", o.wb_count); end
  endtask

  task automatic test_store_byte();
    obs_t o;
    do_op(32'h103, 1'b0, 1, 1'b0, 32'h000000A5, 5'd1, 0, 32'h0, o);
    checks++; if (o.addr !== 32'h100) begin errors++; $display("FAIL sb_addr got %h want 00000100", o.addr); end
    checks++; if (o.be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", o.be); end
    checks++; if (o.wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", o.wdata); end
    checks++; if (o.ready_cycle != 2) begin errors++; $display("FAIL sb_ready got %0d want 2", o.ready_cycle); end
  endtask

  task automatic test_loads();
    obs_t        o;
    int          nb [3] = '{1, 1, 2};
    bit          sx [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] want [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00001280};
    logic [3:0]  be [3] = '{4'b0100, 4'b0100, 4'b1100};
    for (int i = 0; i < 3; i++) begin
      do_op(32'h102, 1'b1, nb[i], sx[i], 32'h0, 5'd5, 0, 32'h1280FF34, o);
      checks++; if (o.wb_value !== want[i]) begin errors++; $display("FAIL load%0d_value got %h want %h", i, o.wb_value, want[i]); end
      checks++; if (o.wb_count != 1) begin errors++; $display("FAIL load%0d_wb_pulses got %0d want 1", i, o.wb_count); end
      checks++; if (o.wb_rd !== 5'd5) begin errors++; $display("FAIL load%0d_rd got %0d want 5", i, o.wb_rd); end
      checks++; if (o.be !== be[i]) begin errors++; $display("FAIL load%0d_be got %b want %b", i, o.be, be[i]); end
      checks++; if (o.wdata !== 32'h0) begin errors++; $display("FAIL load%0d_wdata got %h want 0", i, o.wdata); end
      checks++; if (o.ready_cycle != 3) begin errors++; $display("FAIL load%0d_ready got %0d want 3", i, o.ready_cycle); end
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_op(32'h102, 1'b1, 4, 1'b0, 32'h0, 5'd5, 0, 32'h12345678, o);
    checks++; if (o.mis_count != 1) begin errors++; $display("FAIL mis_pulses got %0d want 1", o.mis_count); end
    checks++; if (o.req_cycles != 0) begin errors++; $display("FAIL mis_req got %0d want 0", o.req_cycles); end
    checks++; if (o.ready_cycle != 2) begin errors++; $display("FAIL mis_ready got %0d want 2", o.ready_cycle); end
    checks++; if (o.wb_count != 0) begin errors++; $display("FAIL mis_wb got %0d want 0", o.wb_count); end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_op(32'h40, 1'b1, 4, 1'b0, 32'h0, 5'd3, 99, 32'h0, o);
    checks++; if (o.req_cycles != MW) begin errors++; $display("FAIL to_req got %0d want %0d", o.req_cycles, MW); end
    checks++; if (o.bus_count != 1) begin errors++; $display("FAIL to_bus_pulses got %0d want 1", o.bus_count); end
    checks++; if (o.wb_count != 0) begin errors++; $display("FAIL to_wb got %0d want 0", o.wb_count); end
    do_op(32'h40, 1'b1, 4, 1'b0, 32'h0, 5'd3, MW - 1, 32'h89ABCDEF, o);
    checks++; if (o.bus_count != 0) begin errors++; $display("FAIL last_ack_bus got %0d want 0", o.bus_count); end
    checks++; if (o.wb_count != 1) begin errors++; $display("FAIL last_ack_wb got %0d want 1", o.wb_count); end
    checks++; if (o.wb_value !== 32'h89ABCDEF) begin errors++; $display("FAIL last_ack_value got %h want 89abcdef", o.wb_value); end
  endtask

  task automatic test_ignored();
    int bad = 0;
    @(negedge clk);
    issue_valid = 1'b1; issue_is_load = 1'b0; issue_mem = '0; issue_addr = 32'h80;
    dmem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (!issue_ready || dmem_req || stall || wb_valid) bad++;
    end
    issue_valid = 1'b0; dmem_ack = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL ignored_op got %0d busy cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   bad = 0;
    @(negedge clk);
    issue_valid = 1'b1; issue_addr = 32'h200; issue_is_load = 1'b1;
    issue_mem.width = MEM_WORD; issue_mem.w_enable = 1'b0; issue_rd = 5'd7;
    @(posedge clk); #1; issue_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rmid_req_before got %b want 1", dmem_req); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({dmem_req, wb_valid, stall} !== 3'b000) begin
      errors++; $display("FAIL rmid_async got req/wb/stall %b want 000", {dmem_req, wb_valid, stall});
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
    #3 reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (wb_valid || dmem_req || stall) bad++;
    end
    dmem_ack = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_after got %0d active cycles want 0", bad); end
    do_op(32'h300, 1'b1, 4, 1'b0, 32'h0, 5'd0, 0, 32'hCAFEF00D, o);
    checks++; if (o.req_cycles != 1) begin errors++; $display("FAIL rd0_req got %0d want 1", o.req_cycles); end
    checks++; if (o.addr !== 32'h300) begin errors++; $display("FAIL rd0_addr got %h want 00000300", o.addr); end
    checks++; if (o.wb_count != 0) begin errors++; $display("FAIL rd0_wb got %0d want 0", o.wb_count); end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [31:0] addr, wval, rdata;
    bit          is_load, sx;
    int          nb, dly;
    rv_reg_t     rd;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom; wval = $urandom; rdata = $urandom;
      is_load = 1'($urandom_range(0, 1)); sx = 1'($urandom_range(0, 1));
      nb = 1 << $urandom_range(0, 2);
      dly = $urandom_range(0, MW);
      rd = 5'($urandom_range(0, 31));
      e = model(addr, is_load, nb, sx, wval, rd, dly, rdata);
      do_op(addr, is_load, nb, sx, wval, rd, dly, rdata, o);
      checks++; if (o.mis_count != int'(e.mis)) begin errors++; $display("FAIL rand%0d_mis got %0d want %0d", i, o.mis_count, e.mis); end
      checks++; if (o.bus_count != int'(e.bus)) begin errors++; $display("FAIL rand%0d_bus got %0d want %0d", i, o.bus_count, e.bus); end
      checks++; if (o.req_cycles != e.req_cycles) begin errors++; $display("FAIL rand%0d_req got %0d want %0d", i, o.req_cycles, e.req_cycles); end
      checks++; if (o.ready_cycle != e.ready_cycle) begin errors++; $display("FAIL rand%0d_ready got %0d want %0d", i, o.ready_cycle, e.ready_cycle); end
      checks++; if (o.wb_count != e.wb_count) begin errors++; $display("FAIL rand%0d_wb got %0d want %0d", i, o.wb_count, e.wb_count); end
      if (e.req_cycles > 0) begin
        checks++;
        if ({o.addr, o.be, o.we, o.wdata} !== {e.addr, e.be, e.we, e.wdata}) begin
          errors++;
          $display("FAIL rand%0d_bus_fields got %h/%b/%b/%h want %h/%b/%b/%h", i,
                   o.addr, o.be, o.we, o.wdata, e.addr, e.be, e.we, e.wdata);
        end
      end
      if (e.wb_count == 1) begin
        checks++;
        if ({o.wb_rd, o.wb_value} !== {rd, e.wb_value}) begin
          errors++;
          $display("FAIL rand%0d_wb_data got rd %0d val %h want rd %0d val %h", i, o.wb_rd, o.wb_value, rd, e.wb_value);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
Multi-cycle load/store controller between the execute stage and the data memory port. It accepts the memory-control bundle and effective address produced by execute, then runs a req/ack transaction against data memory. It handles byte-lane steering, write-data replication, read-data extraction and sign extension, misalignment and timeout faults. It holds the pipeline stalled until the access completes, and presents load results for register writeback.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
MAX_WAIT, 16, maximum number of BUSY cycles to wait for dmem_ack before a bus fault; legal range 1..255.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
issue_valid  in  1  execute stage presents a memory operation this cycle.
issue_ready  out  1  sequencer can accept an operation; high only in IDLE.
issue_addr  in  XLEN  byte effective address (ALU result).
issue_is_load  in  1  operation is a load.
issue_mem  in  compute_mem_control_t  width, r_sign_extend, w_enable, w_value.
issue_rd  in  rv_reg_t  destination register for loads.
dmem_req  out  1  memory request, held high until ack.
dmem_we  out  1  1 = write, 0 = read.
dmem_addr  out  XLEN  word-aligned address: {addr[31:2], 2'b00}.
dmem_wdata  out  XLEN  lane-replicated store data.
dmem_byte_en  out  4  active byte lanes.
dmem_ack  in  1  memory completes the access this cycle; read data is valid alongside it.
dmem_rdata  in  XLEN  read word.
wb_valid  out  1  one-cycle pulse: load result available.
wb_rd  out  rv_reg_t  load destination register.
wb_value  out  XLEN  extended load result.
stall  out  1  high whenever state != IDLE.
misaligned_fault  out  1  one-cycle pulse on a misaligned access.
bus_fault  out  1  one-cycle pulse on a timeout.

Behaviour:
- FSM states: IDLE, BUSY, RESPOND, FAULT.
- Reset (async): state IDLE; every registered output (dmem_*, wb_*, both faults, stall) is 0; internal address, data, rd and counter are 0.
- Accept condition: issue_valid && state==IDLE && (issue_is_load || issue_mem.w_enable).
  - Operations with neither is_load nor w_enable set are ignored and never accepted.
  - On accept, latch addr, width, sign_extend, we, w_value and rd.
- Misalignment check at accept:
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Misaligned: go to FAULT. FAULT drives misaligned_fault=1 for exactly one cycle, then returns to IDLE. dmem_req is never raised.
- Aligned: go to BUSY. dmem_req=1 from the first BUSY cycle, i.e. registered, one cycle after accept. Counter is cleared on entry.
- BUSY, ack=1:
  - Loads latch dmem_rdata and go to RESPOND.
  - Stores go to IDLE.
  - dmem_req drops in the cycle after ack.
- BUSY, ack=0:
  - If counter==MAX_WAIT-1: pulse bus_fault for one cycle, drop dmem_req, go to IDLE. No writeback.
  - Otherwise increment the counter.
  - dmem_req is therefore high for at most MAX_WAIT cycles.
  - Ack in the final allowed cycle takes priority over the timeout.
- RESPOND: wb_valid=1 for one cycle with wb_rd and wb_value, then IDLE.
  - If rd==x0, the memory access still happens but wb_valid stays 0.
- Byte enables, with a = addr[1:0]:
  - Byte: 4'b0001<<a.
  - Half: 4'b0011<<a.
  - Word: 4'b1111.
  - Loads use the same enables.
- Write data:
  - Byte: low byte replicated ×4.
  - Half: low halfword replicated ×2.
  - Word: passed through unchanged.
  - Read transactions drive dmem_wdata=0.
- Load extraction:
  - Shift the latched word right by 8*a.
  - Take the low 8 or 16 bits.
  - Sign-extend if r_sign_extend, else zero-extend.
  - Word loads pass through unchanged.
- Store completion: stores complete with no writeback; wb_valid stays 0.
- Throughput: minimum latency from accept to IDLE is 3 cycles for a load (ack in the first BUSY cycle) and 2 cycles for a store. No back-to-back acceptance.
- Reset mid-transaction: dmem_req and wb_valid drop immediately (async); any pending writeback is discarded.
- dmem_ack outside BUSY is ignored.

Test Plan:
- SW addr 0x100, w_value 0xDEADBEEF, ack on 2nd BUSY cycle -> dmem_addr 0x100, byte_en 4'b1111, we=1, wdata 0xDEADBEEF; stall high from the cycle after accept until back in IDLE; no wb_valid.
- SB addr 0x103, w_value 0x000000A5 -> dmem_addr 0x100, byte_en 4'b1000, wdata 0xA5A5A5A5.
- dmem_rdata 0x1280FF34, rd=5, addr 0x102:
  - LB -> wb_value 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH -> 0x00001280.
  - Each with wb_valid pulsed once and wb_rd=5.
- LW addr 0x102 -> misaligned_fault pulses one cycle, dmem_req never asserted, issue_ready high again 2 cycles after accept.
- MAX_WAIT=4:
  - No ack -> dmem_req high exactly 4 cycles, then bus_fault pulse, no wb_valid.
  - Repeat with ack in the 4th cycle -> normal completion, no bus_fault.
- Assert reset during BUSY of an LW -> dmem_req low immediately, no wb_valid. Afterwards, LW with rd=0 and ack -> dmem access occurs, wb_valid stays 0.
